// File: rtl/diff_manchester_decoder.sv
// Differential Manchester line decoder: oversampled AXI-Stream line samples in,
// packed decoded bits out on AXI-Stream with frame tlast on flush.
module diff_manchester_decoder #(
  parameter int C_S00_AXIS_TDATA_WIDTH = 32,
  parameter int C_M00_AXIS_TDATA_WIDTH = 32,
  parameter int SAMPLES_PER_BIT        = 8,
  parameter int WORD_BITS              = 8
) (
  input  logic                                s00_axis_aclk,
  input  logic                                s00_axis_areset,
  input  logic                                s00_axis_tvalid,
  input  logic                                s00_axis_tlast,
  input  logic [C_S00_AXIS_TDATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [C_S00_AXIS_TDATA_WIDTH/8-1:0] s00_axis_tstrb,
  output logic                                s00_axis_tready,
  input  logic                                m00_axis_tready,
  output logic                                m00_axis_tvalid,
  output logic                                m00_axis_tlast,
  output logic [C_M00_AXIS_TDATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [C_M00_AXIS_TDATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                                locked
);

  localparam int CW = $clog2(SAMPLES_PER_BIT + SAMPLES_PER_BIT/4 + 1);
  localparam int BW = $clog2(WORD_BITS + 1);
  localparam logic [CW-1:0] MID_LIM  = CW'(SAMPLES_PER_BIT/4);
  localparam logic [CW-1:0] BND_LIM  = CW'(3*SAMPLES_PER_BIT/4);
  localparam logic [CW-1:0] LOSS_LIM = CW'(SAMPLES_PER_BIT + SAMPLES_PER_BIT/4);

  typedef enum logic {HUNT, LOCK} state_t;

  state_t                      state_q, state_d;
  logic [CW-1:0]               cnt_q, cnt_d;
  logic                        mid_q, mid_d;
  logic                        prev_q, prev_d;
  logic [BW-1:0]               bcnt_q, bcnt_d;
  logic [WORD_BITS-1:0]        pack_q, pack_d;
  logic                        m_tvalid_q, m_tlast_q, locked_q;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] m_tdata_q;

  logic                        accept, sample, trans;
  logic [CW-1:0]               c;
  logic                        bit_vld, bit_val, flush;
  logic [WORD_BITS-1:0]        pack_new;
  logic [BW-1:0]               bcnt_new;
  logic                        word_ld, word_last;
  logic [C_M00_AXIS_TDATA_WIDTH-1:0] word_data;
  logic                        unused_in;

  assign unused_in = ^{s00_axis_tdata[C_S00_AXIS_TDATA_WIDTH-1:1], s00_axis_tstrb};

  assign s00_axis_tready = !m_tvalid_q || m00_axis_tready;
  assign accept = s00_axis_tvalid && s00_axis_tready;
  assign sample = s00_axis_tdata[0];
  assign trans  = sample != prev_q;
  assign c      = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mid_d   = mid_q;
    prev_d  = prev_q;
    bit_vld = 1'b0;
    bit_val = 1'b0;
    flush   = 1'b0;
    if (accept) begin
      prev_d = sample;
      case (state_q)
        HUNT: begin
          if (trans) begin
            state_d = LOCK;
            cnt_d   = '0;
            mid_d   = 1'b0;
          end
        end
        default: begin
          if (trans && c >= BND_LIM) begin
            bit_vld = 1'b1;
            bit_val = !mid_q;
            cnt_d   = '0;
            mid_d   = 1'b0;
          end else if (trans && c >= MID_LIM) begin
            mid_d = 1'b1;
            cnt_d = c;
          end else if (!trans && c >= LOSS_LIM) begin
            flush   = 1'b1;
            state_d = HUNT;
            cnt_d   = '0;
            mid_d   = 1'b0;
          end else begin
            cnt_d = c;  // includes early glitch transitions
          end
        end
      endcase
      if (s00_axis_tlast) begin
        flush   = 1'b1;
        state_d = HUNT;
        cnt_d   = '0;
        mid_d   = 1'b0;
      end
    end
  end

  // Bit packing; a bit decoded on the flushing sample is included in the flushed word.
  always_comb begin
    pack_new  = bit_vld ? (pack_q | (WORD_BITS'(bit_val) << bcnt_q)) : pack_q;
    bcnt_new  = bit_vld ? bcnt_q + BW'(1) : bcnt_q;
    pack_d    = pack_new;
    bcnt_d    = bcnt_new;
    word_ld   = 1'b0;
    word_last = 1'b0;
    word_data = '0;
    word_data[WORD_BITS-1:0] = pack_new;
    if (bit_vld && bcnt_new == BW'(WORD_BITS)) begin
      word_ld   = 1'b1;
      word_last = s00_axis_tlast;
      pack_d    = '0;
      bcnt_d    = '0;
    end else if (flush) begin
      word_ld   = bcnt_new != '0;
      word_last = 1'b1;
      pack_d    = '0;
      bcnt_d    = '0;
    end
  end

  always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
    if (s00_axis_areset) begin
      state_q    <= HUNT;
      cnt_q      <= '0;
      mid_q      <= 1'b0;
      prev_q     <= 1'b0;
      bcnt_q     <= '0;
      pack_q     <= '0;
      m_tvalid_q <= 1'b0;
      m_tlast_q  <= 1'b0;
      m_tdata_q  <= '0;
      locked_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mid_q    <= mid_d;
      prev_q   <= prev_d;
      bcnt_q   <= bcnt_d;
      pack_q   <= pack_d;
      locked_q <= state_d == LOCK;
      // word_ld only happens on an accepted sample, so the register is free
      if (word_ld) begin
        m_tvalid_q <= 1'b1;
        m_tlast_q  <= word_last;
        m_tdata_q  <= word_data;
      end else if (m00_axis_tready) begin
        m_tvalid_q <= 1'b0;
      end
    end
  end

  assign m00_axis_tvalid = m_tvalid_q;
  assign m00_axis_tlast  = m_tlast_q;
  assign m00_axis_tdata  = m_tdata_q;
  assign m00_axis_tstrb  = '1;
  assign locked          = locked_q;

endmodule

// File: tb/tb_diff_manchester_decoder.sv
// Directed bench for diff_manchester_decoder (SPB=8, WORD_BITS=8).
module tb_diff_manchester_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tready;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tstrb = '1;
  logic        m_tready = 1'b1, m_tvalid, m_tlast, locked;
  logic [31:0] m_tdata;
  logic [3:0]  m_tstrb;

  int   tests = 0, fails = 0;
  logic lvl = 1'b0;
  logic [31:0] q_data[$];
  logic        q_last[$];

  diff_manchester_decoder #(
    .C_S00_AXIS_TDATA_WIDTH(32), .C_M00_AXIS_TDATA_WIDTH(32),
    .SAMPLES_PER_BIT(8), .WORD_BITS(8)
  ) dut (
    .s00_axis_aclk(clk), .s00_axis_areset(rst),
    .s00_axis_tvalid(s_tvalid), .s00_axis_tlast(s_tlast),
    .s00_axis_tdata(s_tdata), .s00_axis_tstrb(s_tstrb),
    .s00_axis_tready(s_tready), .m00_axis_tready(m_tready),
    .m00_axis_tvalid(m_tvalid), .m00_axis_tlast(m_tlast),
    .m00_axis_tdata(m_tdata), .m00_axis_tstrb(m_tstrb),
    .locked(locked)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (!rst && m_tvalid && m_tready) begin
      q_data.push_back(m_tdata);
      q_last.push_back(m_tlast);
    end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic b, input logic last);
    s_tdata  = {31'b0, b};
    s_tvalid = 1'b1;
    s_tlast  = last;
    @(posedge clk); #1;
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  // One 8-sample bit period: boundary toggle, optional mid toggle at sample 4 for a 0.
  task automatic period(input logic b);
    lvl = !lvl;
    repeat (4) send(lvl, 1'b0);
    if (!b) lvl = !lvl;
    repeat (4) send(lvl, 1'b0);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n, input logic last);
    for (int i = 0; i < n; i++) period(v[i]);
    lvl = !lvl;
    send(lvl, last);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    lvl = 1'b0;
    q_data.delete();
    q_last.delete();
  endtask

  task automatic expect_word(input string tag, input logic [31:0] d, input logic l);
    chk({tag, "_count"}, q_data.size(), 1);
    if (q_data.size() > 0) begin
      chk({tag, "_data"}, q_data[0], d);
      chk({tag, "_last"}, q_last[0], l);
    end
    q_data.delete();
    q_last.delete();
  endtask

  initial begin
    idle(2);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tlast", m_tlast, 0);
    chk("rst_tdata", m_tdata, 0);
    chk("rst_locked", locked, 0);
    chk("rst_s_tready", s_tready, 1);
    chk("rst_tstrb", m_tstrb, 4'hF);
    rst = 1'b0;

    repeat (20) send(1'b0, 1'b0);
    idle(2);
    chk("const0_locked", locked, 0);
    chk("const0_words", q_data.size(), 0);

    do_reset();
    send_bits(8'hFF, 8, 1'b0);
    idle(1);
    expect_word("ones", 32'h0000_00FF, 1'b0);
    chk("ones_locked", locked, 1);

    do_reset();
    send_bits(8'h00, 8, 1'b0);
    idle(1);
    expect_word("zeros", 32'h0000_0000, 1'b0);

    do_reset();
    send_bits(8'hA5, 8, 1'b0);
    idle(1);
    expect_word("mixed", 32'h0000_00A5, 1'b0);

    do_reset();
    send_bits(8'h07, 3, 1'b0);
    repeat (9) send(lvl, 1'b0);
    idle(1);
    chk("loss_pre_words", q_data.size(), 0);
    chk("loss_pre_locked", locked, 1);
    send(lvl, 1'b0);
    idle(1);
    expect_word("loss", 32'h0000_0007, 1'b1);
    chk("loss_locked", locked, 0);

    do_reset();
    send_bits(8'h05, 3, 1'b1);
    idle(1);
    expect_word("tlast_flush", 32'h0000_0005, 1'b1);
    chk("tlast_locked", locked, 0);

    do_reset();
    send_bits(8'h3C, 8, 1'b1);
    idle(1);
    expect_word("full_tlast", 32'h0000_003C, 1'b1);

    do_reset();
    m_tready = 1'b0;
    send_bits(8'hFF, 8, 1'b0);
    idle(1);
    chk("bp_tvalid", m_tvalid, 1);
    chk("bp_s_tready", s_tready, 0);
    chk("bp_tdata", m_tdata, 32'h0000_00FF);
    chk("bp_tstrb", m_tstrb, 4'hF);
    idle(3);
    chk("bp_hold_tdata", m_tdata, 32'h0000_00FF);
    chk("bp_hold_tvalid", m_tvalid, 1);
    chk("bp_hold_words", q_data.size(), 0);
    m_tready = 1'b1;
    idle(1);
    chk("bp_rel_s_tready", s_tready, 1);
    chk("bp_rel_tvalid", m_tvalid, 0);
    idle(2);
    expect_word("bp", 32'h0000_00FF, 1'b0);

    do_reset();
    send_bits(8'h1F, 5, 1'b0);
    rst = 1'b1;
    idle(1);
    chk("midrst_locked_in", locked, 0);
    rst = 1'b0;
    lvl = 1'b0;
    idle(2);
    chk("midrst_locked", locked, 0);
    chk("midrst_tvalid", m_tvalid, 0);
    chk("midrst_tdata", m_tdata, 0);
    chk("midrst_tlast", m_tlast, 0);
    chk("midrst_s_tready", s_tready, 1);
    chk("midrst_words", q_data.size(), 0);
    send_bits(8'h81, 8, 1'b0);
    idle(1);
    expect_word("post_rst", 32'h0000_0081, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/diff_manchester_decoder.md
DIFF_MANCHESTER_DECODER -- requirements
Module: diff_manchester_decoder

Interface
REQ-001 Parameter C_S00_AXIS_TDATA_WIDTH, default 32: input stream width; only tdata[0] (the line sample) is used.
REQ-002 Parameter C_M00_AXIS_TDATA_WIDTH, default 32: output stream width.
REQ-003 Parameter SAMPLES_PER_BIT (SPB), default 8: line oversampling ratio; even, >=4.
REQ-004 Parameter WORD_BITS, default 8: decoded bits packed per output word; 1..C_M00_AXIS_TDATA_WIDTH.
REQ-005 s00_axis_aclk  in  1  sole clock; all logic on its rising edge.
REQ-006 s00_axis_areset  in  1  reset, asynchronous, active-high.
REQ-007 s00_axis_tvalid / s00_axis_tlast  in  1 / 1  sample valid; end of capture.
REQ-008 s00_axis_tdata  in  C_S00_AXIS_TDATA_WIDTH  bit 0 = line sample.
REQ-009 s00_axis_tstrb  in  C_S00_AXIS_TDATA_WIDTH/8  ignored.
REQ-010 s00_axis_tready  out  1  sample accepted when tvalid && tready.
REQ-011 m00_axis_tready  in  1  downstream ready.
REQ-012 m00_axis_tvalid / m00_axis_tlast  out  1 / 1  word valid; last word of a frame.
REQ-013 m00_axis_tdata  out  C_M00_AXIS_TDATA_WIDTH  decoded bits LSB-first in [WORD_BITS-1:0], all other bits 0.
REQ-014 m00_axis_tstrb  out  C_M00_AXIS_TDATA_WIDTH/8  all ones whenever tvalid.
REQ-015 locked  out  1  high while in LOCK state.

Function
REQ-016 Coding: every bit period starts with a boundary transition; a mid-bit transition decodes 0, its absence decodes 1.
REQ-017 All decoder state advances only on accepted samples; transition = sample != prev_sample; prev_sample updates on every accepted sample.
REQ-018 States: HUNT, LOCK; HUNT -> LOCK on first accepted transition, which sets cnt=0, mid=0, consumes no bit.
REQ-019 In LOCK, per accepted sample c = cnt+1: transition with c < SPB/4 ignored as glitch; transition with SPB/4 <= c < 3*SPB/4 sets mid=1; transition with c >= 3*SPB/4 is a boundary: emit bit = !mid, cnt=0, mid=0; otherwise cnt=c.
REQ-020 In LOCK, no transition with c >= SPB+SPB/4: loss of lock -> HUNT; no bit emitted for the incomplete period.
REQ-021 Decoded bits shift into the pack register at index = bit count (first bit in bit 0); bit count 0..WORD_BITS-1.
REQ-022 When bit count reaches WORD_BITS, word is loaded into the output register with tlast=0, m00_axis_tvalid high the cycle after the completing sample; bit count returns to 0.
REQ-023 Flush: on loss of lock, or after an accepted sample with s00_axis_tlast=1, pending bits (count >=1) emit one word, zero-filled above count, tlast=1; count 0 emits nothing; both cases go to HUNT.
REQ-024 If the completing sample also has s00_axis_tlast=1, the full word carries tlast=1.
REQ-025 s00_axis_tready = !m00_axis_tvalid || m00_axis_tready; output register never overwritten while valid and not accepted.
REQ-026 m00_axis_tdata/tlast stable while tvalid && !tready; tvalid drops after acceptance unless a new word loads that cycle.
REQ-027 Throughput: one sample per cycle with m00_axis_tready held high.

Reset
REQ-028 While s00_axis_areset is high: state HUNT, cnt=0, mid=0, prev_sample=0, bit count 0, pack register 0.
REQ-029 Reset values: m00_axis_tvalid=0, m00_axis_tlast=0, m00_axis_tdata=0, locked=0, s00_axis_tready=1 (tstrb all ones).
REQ-030 Reset mid-frame discards pending bits and any unaccepted output word; no word emitted.

Verification (SPB=8, WORD_BITS=8, m00_axis_tready=1 unless stated)
REQ-031 20 samples of constant 0 after reset -> locked=0, no output word.
REQ-032 Line toggling every 8 samples, 9 boundaries -> one word 0x000000FF, tlast=0, locked=1.
REQ-033 Boundary every 8 samples plus mid toggle at sample 4 of each period, 8 periods -> word 0x00000000, tlast=0.
REQ-034 3 bits of 1 then line held constant 10 samples -> word 0x00000007, tlast=1, locked=0 on loss.
REQ-035 m00_axis_tready=0 with word 0xFF pending -> s00_axis_tready=0, tdata held 0xFF; raise tready -> word accepted once, s00_axis_tready=1 next cycle.
REQ-036 Reset asserted after 5 decoded bits, then released -> no output word, locked=0, all outputs at reset values.
